// File: rtl/mem_access_unit_if.sv
// Data-bus handshake bundle between mem_access_unit (master) and the data memory (slave).
interface mem_access_unit_if #(
  parameter int unsigned AW = 32
);
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_wstrb;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  modport master (
    output d_req, d_wr, d_addr, d_wstrb, d_wdata,
    input  d_gnt, d_rvalid, d_rdata
  );

  modport slave (
    input  d_req, d_wr, d_addr, d_wstrb, d_wdata,
    output d_gnt, d_rvalid, d_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues handshaked bus accesses, formats store/load data, drives result_M.
// Define MEM_ALIGN_CHECK_EN to enable misalignment traps; otherwise low address bits are force-aligned.
module mem_access_unit #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_rd_M,
  input  logic          mem_wr_M,
  input  logic [1:0]    mem_size_M,
  input  logic          mem_unsigned_M,
  input  logic [AW-1:0] alu_out_M,
  input  logic [31:0]   wr_data_M,
  input  logic          flush_M,
  input  logic          hold_M,
  output logic [31:0]   result_M,
  output logic          stall_M,
  output logic          addr_err_ld_M,
  output logic          addr_err_st_M,
  mem_access_unit_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] RESP  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          d_req_q, d_req_d;
  logic          d_wr_q, d_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          load_q, load_d;
  logic [31:0]   result_q, result_d;

  logic [AW-1:0] eff_addr;
  logic          misaligned;
  logic          valid_acc;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_fmt;

  always_comb begin
    eff_addr   = alu_out_M;
    misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    case (mem_size_M)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_out_M[0];
      default: misaligned = |alu_out_M[1:0];
    endcase
`else
    case (mem_size_M)
      2'b00:   ;
      2'b01:   eff_addr[0] = 1'b0;
      default: eff_addr[1:0] = 2'b00;
    endcase
`endif
  end

  assign valid_acc = (mem_rd_M | mem_wr_M) & ~flush_M & ~misaligned;

  always_comb begin
    st_wdata = wr_data_M;
    st_wstrb = 4'b1111;
    case (mem_size_M)
      2'b00: begin
        st_wdata = {4{wr_data_M[7:0]}};
        st_wstrb = 4'b0001 << eff_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{wr_data_M[15:0]}};
        st_wstrb = eff_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = bus.d_rdata[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];
    case (size_q)
      2'b00:   ld_fmt = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   ld_fmt = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: ld_fmt = bus.d_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    d_req_d  = d_req_q;
    d_wr_d   = d_wr_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    load_d   = load_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (valid_acc) begin
          state_d = REQ;
          d_req_d = 1'b1;
          d_wr_d  = mem_wr_M;
          addr_d  = {eff_addr[AW-1:2], 2'b00};
          wstrb_d = mem_wr_M ? st_wstrb : 4'b0000;
          wdata_d = mem_wr_M ? st_wdata : 32'h0;
          off_d   = eff_addr[1:0];
          size_d  = mem_size_M;
          uns_d   = mem_unsigned_M;
          load_d  = mem_rd_M;
        end
      end
      REQ: begin
        // A grant commits the access even if a flush lands in the same cycle.
        if (bus.d_gnt) begin
          d_req_d = 1'b0;
          if (!load_q)      state_d = DONE;
          else if (flush_M) state_d = DRAIN;
          else              state_d = RESP;
        end else if (flush_M) begin
          d_req_d = 1'b0;
          state_d = IDLE;
        end
      end
      RESP: begin
        // Flush with data already arriving has nothing left to drain.
        if (flush_M) begin
          state_d = bus.d_rvalid ? IDLE : DRAIN;
        end else if (bus.d_rvalid) begin
          result_d = ld_fmt;
          state_d  = DONE;
        end
      end
      DRAIN: if (bus.d_rvalid) state_d = IDLE;
      DONE:  if (!hold_M) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      d_req_q  <= 1'b0;
      d_wr_q   <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= 32'h0;
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      load_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      d_req_q  <= d_req_d;
      d_wr_q   <= d_wr_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      load_q   <= load_d;
      result_q <= result_d;
    end
  end

  assign bus.d_req   = d_req_q;
  assign bus.d_wr    = d_wr_q;
  assign bus.d_addr  = addr_q;
  assign bus.d_wstrb = wstrb_q;
  assign bus.d_wdata = wdata_q;

  assign stall_M = (state_q == REQ) | (state_q == RESP) | (state_q == DRAIN) |
                   ((state_q == IDLE) & valid_acc);
  assign result_M = ((state_q == DONE) & load_q) ? result_q : 32'(alu_out_M);

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err_ld_M = (state_q == IDLE) & mem_rd_M & ~flush_M & misaligned;
  assign addr_err_st_M = (state_q == IDLE) & mem_wr_M & ~flush_M & misaligned;
`else
  assign addr_err_ld_M = 1'b0;
  assign addr_err_st_M = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; bench drives the bus slave side by hand each cycle.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_M, mem_wr_M, mem_unsigned_M, flush_M, hold_M;
  logic [1:0]  mem_size_M;
  logic [31:0] alu_out_M, wr_data_M, result_M;
  logic        stall_M, addr_err_ld_M, addr_err_st_M;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.AW(32)) bus ();

  mem_access_unit #(.AW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd_M      (mem_rd_M),
    .mem_wr_M      (mem_wr_M),
    .mem_size_M    (mem_size_M),
    .mem_unsigned_M(mem_unsigned_M),
    .alu_out_M     (alu_out_M),
    .wr_data_M     (wr_data_M),
    .flush_M       (flush_M),
    .hold_M        (hold_M),
    .result_M      (result_M),
    .stall_M       (stall_M),
    .addr_err_ld_M (addr_err_ld_M),
    .addr_err_st_M (addr_err_st_M),
    .bus           (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic nop_inputs(input logic [31:0] alu);
    mem_rd_M = 0; mem_wr_M = 0; mem_size_M = 2'b10; mem_unsigned_M = 0;
    alu_out_M = alu; wr_data_M = 0; flush_M = 0; hold_M = 0;
    bus.d_gnt = 0; bus.d_rvalid = 0; bus.d_rdata = 0;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data);
    mem_rd_M = rd; mem_wr_M = wr; mem_size_M = sz; mem_unsigned_M = uns;
    alu_out_M = addr; wr_data_M = data;
  endtask

  task automatic test_reset;
    settle;
    checks++;
    if ({bus.d_req, bus.d_wr, bus.d_addr, bus.d_wstrb, bus.d_wdata} !== 70'h0) begin
      errors++; $display("FAIL reset_bus: got %h want 0",
                         {bus.d_req, bus.d_wr, bus.d_addr, bus.d_wstrb, bus.d_wdata});
    end
    checks++;
    if ({stall_M, addr_err_ld_M, addr_err_st_M, result_M} !== {3'b000, 32'h1234}) begin
      errors++; $display("FAIL reset_out: got %b %b %b %h want 0 0 0 00001234",
                         stall_M, addr_err_ld_M, addr_err_st_M, result_M);
    end
  endtask

  task automatic test_lw;
    tick; set_mem(1, 0, 2'b10, 0, 32'h1004, 0); bus.d_gnt = 1; settle;
    checks++;
    if ({stall_M, bus.d_req} !== 2'b10) begin
      errors++; $display("FAIL lw_idle: stall/req got %b want 10", {stall_M, bus.d_req});
    end
    tick; settle;
    checks++;
    if ({stall_M, bus.d_req, bus.d_wr, bus.d_addr, bus.d_wstrb} !== {3'b110, 32'h1004, 4'h0}) begin
      errors++; $display("FAIL lw_req: got %b %b %b %h %b want 1 1 0 00001004 0000",
                         stall_M, bus.d_req, bus.d_wr, bus.d_addr, bus.d_wstrb);
    end
    tick; bus.d_gnt = 0; bus.d_rvalid = 1; bus.d_rdata = 32'hDEAD_BEEF; settle;
    checks++;
    if ({stall_M, bus.d_req} !== 2'b10) begin
      errors++; $display("FAIL lw_resp: stall/req got %b want 10", {stall_M, bus.d_req});
    end
    tick; bus.d_rvalid = 0; settle;
    checks++;
    if ({stall_M, result_M} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL lw_done: got %b %h want 0 deadbeef", stall_M, result_M);
    end
    tick; nop_inputs(32'h55); settle;
    checks++;
    if ({stall_M, result_M} !== {1'b0, 32'h55}) begin
      errors++; $display("FAIL lw_after: got %b %h want 0 00000055", stall_M, result_M);
    end
  endtask

  task automatic test_lb_extend;
    logic [31:0] exp [2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int u = 0; u < 2; u++) begin
      tick; set_mem(1, 0, 2'b00, u[0], 32'h2003, 0); bus.d_gnt = 1; settle;
      tick; settle;
      checks++;
      if (bus.d_addr !== 32'h2000) begin
        errors++; $display("FAIL lb_addr%0d: got %h want 00002000", u, bus.d_addr);
      end
      tick; bus.d_gnt = 0; bus.d_rvalid = 1; bus.d_rdata = 32'h80FF_FFFF; settle;
      tick; bus.d_rvalid = 0; settle;
      checks++;
      if (result_M !== exp[u]) begin
        errors++; $display("FAIL lb_result%0d: got %h want %h", u, result_M, exp[u]);
      end
      tick; nop_inputs(0);
    end
  endtask

  task automatic test_store_formats;
    logic [1:0]  sz  [2] = '{2'b00, 2'b10};
    logic [31:0] ad  [2] = '{32'h4001, 32'h4008};
    logic [31:0] rt  [2] = '{32'h7777_775A, 32'hCAFE_1234};
    logic [31:0] ewd [2] = '{32'h5A5A_5A5A, 32'hCAFE_1234};
    logic [3:0]  ews [2] = '{4'b0010, 4'b1111};
    for (int i = 0; i < 2; i++) begin
      tick; set_mem(0, 1, sz[i], 0, ad[i], rt[i]); bus.d_gnt = 1; settle;
      tick; settle;
      checks++;
      if ({stall_M, bus.d_wr, bus.d_wdata, bus.d_wstrb} !== {2'b11, ewd[i], ews[i]}) begin
        errors++; $display("FAIL st_fmt%0d: got %b %b %h %b want 1 1 %h %b", i, stall_M,
                           bus.d_wr, bus.d_wdata, bus.d_wstrb, ewd[i], ews[i]);
      end
      tick; bus.d_gnt = 0; settle;
      checks++;
      if ({stall_M, bus.d_req, result_M} !== {2'b00, ad[i]}) begin
        errors++; $display("FAIL st_done%0d: got %b %b %h want 0 0 %h",
                           i, stall_M, bus.d_req, result_M, ad[i]);
      end
      tick; nop_inputs(0);
    end
  endtask

  task automatic test_sh_delayed_gnt;
    tick; set_mem(0, 1, 2'b01, 0, 32'h3002, 32'h1234_ABCD); settle;
    for (int i = 0; i < 4; i++) begin
      tick; settle;
      checks++;
      if ({stall_M, bus.d_req, bus.d_wr, bus.d_addr, bus.d_wstrb, bus.d_wdata} !==
          {3'b111, 32'h3000, 4'b1100, 32'hABCD_ABCD}) begin
        errors++; $display("FAIL sh_wait%0d: got %b %b %b %h %b %h want 1 1 1 00003000 1100 abcdabcd",
                           i, stall_M, bus.d_req, bus.d_wr, bus.d_addr, bus.d_wstrb, bus.d_wdata);
      end
    end
    tick; bus.d_gnt = 1; settle;
    tick; bus.d_gnt = 0; settle;
    checks++;
    if ({stall_M, bus.d_req, result_M} !== {2'b00, 32'h3002}) begin
      errors++; $display("FAIL sh_done: got %b %b %h want 0 0 00003002",
                         stall_M, bus.d_req, result_M);
    end
    tick; nop_inputs(0);
  endtask

  task automatic test_misaligned;
`ifdef MEM_ALIGN_CHECK_EN
    tick; set_mem(1, 0, 2'b10, 0, 32'h4006, 0); bus.d_gnt = 1; settle;
    checks++;
    if ({addr_err_ld_M, addr_err_st_M, stall_M, result_M} !== {3'b100, 32'h4006}) begin
      errors++; $display("FAIL mis_ld: got %b %b %b %h want 1 0 0 00004006",
                         addr_err_ld_M, addr_err_st_M, stall_M, result_M);
    end
    tick; settle;
    checks++;
    if (bus.d_req !== 1'b0) begin
      errors++; $display("FAIL mis_ld_noreq: got %b want 0", bus.d_req);
    end
    set_mem(0, 1, 2'b01, 0, 32'h4005, 0); settle;
    checks++;
    if ({addr_err_ld_M, addr_err_st_M, stall_M} !== 3'b010) begin
      errors++; $display("FAIL mis_st: got %b %b %b want 0 1 0",
                         addr_err_ld_M, addr_err_st_M, stall_M);
    end
    tick; nop_inputs(0);
`else
    tick; set_mem(1, 0, 2'b10, 0, 32'h4006, 0); bus.d_gnt = 1; settle;
    checks++;
    if ({addr_err_ld_M, stall_M} !== 2'b01) begin
      errors++; $display("FAIL mis_ld: err/stall got %b want 01", {addr_err_ld_M, stall_M});
    end
    tick; settle;
    checks++;
    if ({bus.d_req, bus.d_addr} !== {1'b1, 32'h4004}) begin
      errors++; $display("FAIL mis_ld_addr: got %b %h want 1 00004004", bus.d_req, bus.d_addr);
    end
    tick; bus.d_gnt = 0; bus.d_rvalid = 1; bus.d_rdata = 32'h1122_3344; settle;
    tick; bus.d_rvalid = 0; settle;
    checks++;
    if (result_M !== 32'h1122_3344) begin
      errors++; $display("FAIL mis_ld_data: got %h want 11223344", result_M);
    end
    tick; nop_inputs(0);
`endif
  endtask

  task automatic test_flush;
    // Flush in RESP: stall until the pending read returns, data discarded.
    tick; set_mem(1, 0, 2'b10, 0, 32'h5000, 0); bus.d_gnt = 1;
    tick; 
    tick; bus.d_gnt = 0; flush_M = 1; settle;
    tick; nop_inputs(32'h77); settle;
    checks++;
    if (stall_M !== 1'b1) begin
      errors++; $display("FAIL drain_stall: got %b want 1", stall_M);
    end
    tick; tick; bus.d_rvalid = 1; bus.d_rdata = 32'hCAFE_F00D; settle;
    checks++;
    if (stall_M !== 1'b1) begin
      errors++; $display("FAIL drain_rvalid: got %b want 1", stall_M);
    end
    tick; bus.d_rvalid = 0; settle;
    checks++;
    if ({stall_M, result_M} !== {1'b0, 32'h77}) begin
      errors++; $display("FAIL drain_idle: got %b %h want 0 00000077", stall_M, result_M);
    end
    // Flush in REQ before grant aborts the request.
    tick; set_mem(1, 0, 2'b10, 0, 32'h7000, 0);
    tick; flush_M = 1; settle;
    tick; nop_inputs(32'h70); settle;
    checks++;
    if ({bus.d_req, stall_M} !== 2'b00) begin
      errors++; $display("FAIL flush_req: req/stall got %b want 00", {bus.d_req, stall_M});
    end
    // Flush together with grant on a load: grant wins, read is drained.
    tick; set_mem(1, 0, 2'b10, 0, 32'h7200, 0); bus.d_gnt = 1;
    tick; flush_M = 1;
    tick; nop_inputs(32'h72); settle;
    checks++;
    if (stall_M !== 1'b1) begin
      errors++; $display("FAIL flush_gnt: got %b want 1", stall_M);
    end
    tick; bus.d_rvalid = 1;
    tick; bus.d_rvalid = 0; settle;
    checks++;
    if (stall_M !== 1'b0) begin
      errors++; $display("FAIL flush_gnt_end: got %b want 0", stall_M);
    end
  endtask

  task automatic test_hold;
    tick; set_mem(1, 0, 2'b10, 0, 32'h6000, 0); bus.d_gnt = 1;
    tick;
    tick; bus.d_gnt = 0; bus.d_rvalid = 1; bus.d_rdata = 32'h0BAD_F00D;
    tick; bus.d_rvalid = 0; hold_M = 1;
    for (int i = 0; i < 3; i++) begin
      tick; settle;
      checks++;
      if ({stall_M, result_M} !== {1'b0, 32'h0BAD_F00D}) begin
        errors++; $display("FAIL hold%0d: got %b %h want 0 0badf00d", i, stall_M, result_M);
      end
    end
    hold_M = 0;
    tick; nop_inputs(32'h99); settle;
    checks++;
    if (result_M !== 32'h99) begin
      errors++; $display("FAIL hold_release: got %h want 00000099", result_M);
    end
  endtask

  task automatic test_reset_mid;
    tick; set_mem(1, 0, 2'b10, 0, 32'h8000, 0);
    tick; settle;
    checks++;
    if (bus.d_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got %b want 1", bus.d_req);
    end
    rst = 0; settle;
    checks++;
    if ({bus.d_req, bus.d_addr} !== 33'h0) begin
      errors++; $display("FAIL rstmid_clear: got %b %h want 0 00000000", bus.d_req, bus.d_addr);
    end
    tick; rst = 1; set_mem(1, 0, 2'b10, 0, 32'h8004, 0); bus.d_gnt = 1;
    tick;
    tick; bus.d_gnt = 0; bus.d_rvalid = 1; bus.d_rdata = 32'h600D_F00D;
    tick; bus.d_rvalid = 0; settle;
    checks++;
    if ({stall_M, result_M} !== {1'b0, 32'h600D_F00D}) begin
      errors++; $display("FAIL rstmid_lw: got %b %h want 0 600df00d", stall_M, result_M);
    end
    tick; nop_inputs(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0;
    nop_inputs(32'h1234);
    test_reset;
    tick; rst = 1;
    test_lw;
    test_lb_extend;
    test_store_formats;
    test_sh_delayed_gnt;
    test_misaligned;
    test_flush;
    test_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
